us_delay_counter: RTL and testbench



---
 rtl/delay_pkg.sv | 25 ++
 rtl/us_delay_counter.sv | 79 +++++++
 tb/tb_us_delay_counter.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/delay_pkg.sv
// -----------------------------------------------------------------------------
// delay_pkg
//
// Shared helpers for microsecond delay timers. The LCD controller and
// us_delay_counter both use these to size their delay counters.
//
//   cycles_for_us(mhz, us) : number of system-clock cycles in `us` microseconds
//                            for a clock of `mhz` MHz.
//   cnt_width(n)           : bit width of an unsigned counter that must reach n
//                            (inclusive).
// -----------------------------------------------------------------------------
package delay_pkg;

  // Cycle count of a delay. Both arguments are whole numbers, so the product
  // is exact.
  function automatic int cycles_for_us(input int mhz, input int us);
    return mhz * us;
  endfunction

  // The counter has to hold the value n itself, so size it for n+1 states.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage : delay_pkg

// File: rtl/us_delay_counter.sv
// -----------------------------------------------------------------------------
// us_delay_counter
//
// Microsecond delay timer for LCD reset pulses and power-up waits. While
// `start` is held high, the timer counts system-clock cycles. Once
// CLOCK_SPEED_MHZ*US_DELAY cycles have elapsed, it raises `out` and keeps it
// high until `start` drops. Dropping `start` clears the timer completely, so
// the next assertion always starts a fresh, full-length delay.
//
// Parameters:
//   CLOCK_SPEED_MHZ : system clock frequency in MHz (>= 1)
//   US_DELAY        : delay length in microseconds (>= 1)
//
// Ports:
//   CLK       in   1   system clock, rising-edge active
//   RST_N     in   1   asynchronous active-low reset
//   start     in   1   level enable: high = run/hold the delay, low = clear
//   out       out  1   delay-elapsed flag, driven straight from a flop
//   remaining out  CW  TARGET-count, combinational
//                      (present only when US_DELAY_COUNTER_REMAINING_EN is
//                      defined)
//
// Optional feature macro: US_DELAY_COUNTER_REMAINING_EN
// -----------------------------------------------------------------------------
module us_delay_counter
  import delay_pkg::*;
#(
  parameter  int CLOCK_SPEED_MHZ = 12,
  parameter  int US_DELAY        = 2,
  localparam int TARGET          = cycles_for_us(CLOCK_SPEED_MHZ, US_DELAY),
  localparam int CW              = cnt_width(TARGET)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          start,
`ifdef US_DELAY_COUNTER_REMAINING_EN
  output logic [CW-1:0] remaining,
`endif
  output logic          out
);

  // A zero-length delay is meaningless, so refuse to elaborate one.
  if (CLOCK_SPEED_MHZ < 1) begin : g_bad_clock
    $error("us_delay_counter: CLOCK_SPEED_MHZ must be >= 1");
  end
  if (US_DELAY < 1) begin : g_bad_delay
    $error("us_delay_counter: US_DELAY must be >= 1");
  end

  localparam logic [CW-1:0] TARGET_C = CW'(TARGET);
  localparam logic [CW-1:0] LAST_C   = CW'(TARGET - 1);

  logic [CW-1:0] count;

  // Counter and flag together. The counter saturates at TARGET instead of
  // wrapping, so `out` cannot fall again while start is held. `out` is set on
  // the edge at which count moves from TARGET-1 to TARGET. This makes it
  // rise after exactly TARGET edges with start high.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count <= '0;
      out   <= 1'b0;
    end else if (!start) begin
      count <= '0;
      out   <= 1'b0;
    end else if (count != TARGET_C) begin
      count <= count + 1'b1;
      if (count == LAST_C) begin
        out <= 1'b1;
      end
    end
  end

`ifdef US_DELAY_COUNTER_REMAINING_EN
  // Cycles still to go. This reads TARGET while idle and 0 once out is high.
  assign remaining = TARGET_C - count;
`endif

endmodule : us_delay_counter

// File: tb/tb_us_delay_counter.sv
// -----------------------------------------------------------------------------
// tb_us_delay_counter
//
// Self-checking bench for us_delay_counter.
//
// The main instance uses 12 MHz and 2 us, so TARGET = 24. A second instance
// uses 1 MHz and 1 us, so TARGET = 1. For the main instance, a reference
// model derived from the timer's behaviour predicts the counter and flag each
// cycle. The prediction is pushed to a queue when stimulus is driven, then
// popped and compared after the clock edge.
// -----------------------------------------------------------------------------
module tb_us_delay_counter;

  localparam int T = 24;

  typedef struct {
    logic out;
    int   count;
  } exp_t;

  logic CLK;
  logic RST_N;
  logic start;
  logic out;
  logic start_one;
  logic out_one;
`ifdef US_DELAY_COUNTER_REMAINING_EN
  logic [4:0] remaining;
  logic [0:0] remaining_one;
`endif

  int   vectors;
  int   miscompares;
  exp_t sb[$];
  int   mc;
  logic mo;

  us_delay_counter #(.CLOCK_SPEED_MHZ(12), .US_DELAY(2)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .start     (start),
`ifdef US_DELAY_COUNTER_REMAINING_EN
    .remaining (remaining),
`endif
    .out       (out)
  );

  us_delay_counter #(.CLOCK_SPEED_MHZ(1), .US_DELAY(1)) dut_one (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .start     (start_one),
`ifdef US_DELAY_COUNTER_REMAINING_EN
    .remaining (remaining_one),
`endif
    .out       (out_one)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Compare the DUT against one expected record.
  task automatic compare_now(input string name, input exp_t e);
    vectors++;
    if (out !== e.out) begin
      miscompares++;
      $display("[TB] FAIL %s out: got %b expected %b at %0t", name, out, e.out, $time);
    end
    vectors++;
    if (int'(dut.count) !== e.count) begin
      miscompares++;
      $display("[TB] FAIL %s count: got %0d expected %0d at %0t", name, dut.count, e.count, $time);
    end
`ifdef US_DELAY_COUNTER_REMAINING_EN
    vectors++;
    if (int'(remaining) !== T - e.count) begin
      miscompares++;
      $display("[TB] FAIL %s remaining: got %0d expected %0d at %0t", name, remaining, T - e.count, $time);
    end
`endif
  endtask

  // Drive one cycle. The caller must be away from clock edges (posedge+1).
  // This sets start, predicts the next state, waits for the edge, then checks.
  task automatic drive_cycle(input string name, input logic s);
    exp_t e;
    start = s;
    if (!RST_N || !s) begin
      mc = 0;
      mo = 1'b0;
    end else if (mc < T) begin
      if (mc == T - 1) mo = 1'b1;
      mc++;
    end
    e.out = mo;
    e.count = mc;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    compare_now(name, e);
  endtask

  // Bounded wait for out. Returns the number of edges with start high until
  // out is seen, or -1 if the budget runs out.
  task automatic edges_to_out(input string name, output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      drive_cycle(name, 1'b1);
      if (out === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    exp_t e;
    // Asynchronous assertion with no clock edge involved.
    RST_N = 1'b0;
    #1;
    mc = 0;
    mo = 1'b0;
    e.out = 1'b0;
    e.count = 0;
    compare_now("reset_async", e);
    for (int i = 0; i < 5; i++) drive_cycle("reset_hold", 1'b1);
    RST_N = 1'b1;
  endtask

  task automatic test_basic();
    int n;
    edges_to_out("basic", n);
    vectors++;
    if (n !== T) begin
      miscompares++;
      $display("[TB] FAIL basic_latency: got %0d edges expected %0d", n, T);
    end
    for (int i = 0; i < 50; i++) drive_cycle("basic_hold", 1'b1);
  endtask

  task automatic test_clear_restart();
    int n;
    drive_cycle("clear", 1'b0);
    edges_to_out("restart", n);
    vectors++;
    if (n !== T) begin
      miscompares++;
      $display("[TB] FAIL restart_latency: got %0d edges expected %0d", n, T);
    end
  endtask

  task automatic test_abort();
    int n;
    drive_cycle("abort_idle", 1'b0);
    for (int i = 0; i < 10; i++) drive_cycle("abort_run", 1'b1);
    drive_cycle("abort_drop", 1'b0);
    edges_to_out("abort_resume", n);
    vectors++;
    if (n !== T) begin
      miscompares++;
      $display("[TB] FAIL abort_latency: got %0d edges expected %0d", n, T);
    end
  endtask

  task automatic test_async_reset_mid();
    exp_t e;
    int   n;
    drive_cycle("mid_idle", 1'b0);
    for (int i = 0; i < 15; i++) drive_cycle("mid_run", 1'b1);
    #2;
    RST_N = 1'b0;
    #1;
    mc = 0;
    mo = 1'b0;
    e.out = 1'b0;
    e.count = 0;
    compare_now("mid_reset_async", e);
    drive_cycle("mid_reset_hold", 1'b1);
    RST_N = 1'b1;
    edges_to_out("mid_after", n);
    vectors++;
    if (n !== T) begin
      miscompares++;
      $display("[TB] FAIL mid_reset_latency: got %0d edges expected %0d", n, T);
    end
  endtask

  task automatic test_target_one();
    vectors++;
    if (out_one !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL one_idle: got %b expected 0", out_one);
    end
    start_one = 1'b1;
    @(posedge CLK);
    #1;
    vectors++;
    if (out_one !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL one_rise: got %b expected 1", out_one);
    end
    start_one = 1'b0;
    @(posedge CLK);
    #1;
    vectors++;
    if (out_one !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL one_clear: got %b expected 0", out_one);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    mc = 0;
    mo = 1'b0;
    RST_N = 1'b1;
    start = 1'b0;
    start_one = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_clear_restart();
    test_abort();
    test_async_reset_mid();
    test_target_one();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_us_delay_counter
